// File: rtl/cordic_vectoring_if.sv
// Request/result bundle for the vectoring CORDIC: operands in, phase/magnitude out,
// with the start/recived/valid handshake.
interface cordic_vectoring_if #(
    parameter int ANGLE_W = 18
);
    logic                      start;
    logic signed [15:0]        x_in;
    logic signed [15:0]        y_in;
    logic signed [ANGLE_W-1:0] angle_out;
    logic        [15:0]        mag_out;
    logic                      recived;
    logic                      valid;

    modport master (
        output start, x_in, y_in,
        input  angle_out, mag_out, recived, valid
    );

    modport slave (
        input  start, x_in, y_in,
        output angle_out, mag_out, recived, valid
    );
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: converts (x,y) into atan2 phase and gain-compensated
// magnitude, using the same angle scale and arctangent table as the rotation CORDIC.
module cordic_vectoring #(
    parameter int NUMBER_OF_ITERATIONS = 16,
    parameter int ANGLE_W              = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    cordic_vectoring_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        CHECK  = 3'd2,
        ROTATE = 3'd3,
        SCALE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [4:0]                N_ITER    = 5'(NUMBER_OF_ITERATIONS);
    localparam logic signed [ANGLE_W-1:0] ANGLE_PI  = ANGLE_W'(17'h10000);
    localparam logic [15:0]               GAIN_COMP = 16'h4DBA;

    function automatic logic [15:0] atan_lut(input logic [3:0] idx);
        logic [15:0] val;
        case (idx)
            4'd0:    val = 16'h4000;
            4'd1:    val = 16'h25C8;
            4'd2:    val = 16'h13F6;
            4'd3:    val = 16'h0A22;
            4'd4:    val = 16'h0516;
            4'd5:    val = 16'h028B;
            4'd6:    val = 16'h0145;
            4'd7:    val = 16'h00A2;
            4'd8:    val = 16'h0051;
            4'd9:    val = 16'h0029;
            4'd10:   val = 16'h0014;
            4'd11:   val = 16'h000A;
            4'd12:   val = 16'h0005;
            4'd13:   val = 16'h0003;
            4'd14:   val = 16'h0002;
            4'd15:   val = 16'h0001;
            default: val = 16'h0000;
        endcase
        return val;
    endfunction

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic signed [17:0]        xw_r;
    logic signed [17:0]        yw_r;
    logic signed [ANGLE_W-1:0] zw_r;
    logic        [4:0]         i_r;
    logic                      zero_r;

    logic signed [17:0]        xs_s;
    logic signed [17:0]        ys_s;
    logic signed [ANGLE_W-1:0] atan_s;
    logic        [33:0]        mag_prod_s;
    logic        [15:0]        mag_scaled_s;

    // Shifted operands, current table angle and the gain-compensated magnitude.
    always_comb begin
        xs_s         = xw_r >>> i_r;
        ys_s         = yw_r >>> i_r;
        atan_s       = signed'({{(ANGLE_W-16){1'b0}}, atan_lut(i_r[3:0])});
        mag_prod_s   = {16'd0, xw_r} * {18'd0, GAIN_COMP};
        mag_scaled_s = 16'(mag_prod_s >> 15);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a zero vector still passes through INIT so recived gets its clear cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_nxt_s = INIT;
                else           state_nxt_s = IDLE;
            end
            INIT: begin
                if (zero_r) state_nxt_s = DONE;
                else        state_nxt_s = CHECK;
            end
            CHECK: begin
                if (i_r < N_ITER) state_nxt_s = ROTATE;
                else              state_nxt_s = SCALE;
            end
            ROTATE:  state_nxt_s = CHECK;
            SCALE:   state_nxt_s = DONE;
            DONE: begin
                if (bus.start) state_nxt_s = DONE;
                else           state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath and registered outputs; results change only in SCALE or the zero shortcut.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xw_r          <= 18'sd0;
            yw_r          <= 18'sd0;
            zw_r          <= '0;
            i_r           <= 5'd0;
            zero_r        <= 1'b0;
            bus.angle_out <= '0;
            bus.mag_out   <= 16'd0;
            bus.recived   <= 1'b0;
            bus.valid     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    bus.valid <= 1'b0;
                    if (bus.start) begin
                        bus.recived <= 1'b1;
                        xw_r        <= {{2{bus.x_in[15]}}, bus.x_in};
                        yw_r        <= {{2{bus.y_in[15]}}, bus.y_in};
                        zero_r      <= (bus.x_in == 16'sd0) && (bus.y_in == 16'sd0);
                        if ((bus.x_in == 16'sd0) && (bus.y_in == 16'sd0)) begin
                            bus.angle_out <= '0;
                            bus.mag_out   <= 16'd0;
                        end
                    end
                end
                INIT: begin
                    bus.recived <= 1'b0;
                    i_r         <= 5'd0;
                    // Left half-plane: rotate by pi so the iterations only see |angle| <= pi/2.
                    if (xw_r[17]) begin
                        xw_r <= -xw_r;
                        yw_r <= -yw_r;
                        zw_r <= yw_r[17] ? -ANGLE_PI : ANGLE_PI;
                    end else begin
                        zw_r <= '0;
                    end
                end
                ROTATE: begin
                    if (!yw_r[17]) begin
                        xw_r <= xw_r + ys_s;
                        yw_r <= yw_r - xs_s;
                        zw_r <= zw_r + atan_s;
                    end else begin
                        xw_r <= xw_r - ys_s;
                        yw_r <= yw_r + xs_s;
                        zw_r <= zw_r - atan_s;
                    end
                    i_r <= i_r + 5'd1;
                end
                SCALE: begin
                    bus.angle_out <= zw_r;
                    bus.mag_out   <= mag_scaled_s;
                end
                DONE: begin
                    bus.valid   <= 1'b1;
                    bus.recived <= 1'b0;
                end
                default: begin
                    bus.valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
